// File: rtl/fifo_w2n_flush.sv
// Asymmetric 32-bit-in / 4-bit-out FIFO with per-entry nibble counts and a flush that discards captured entries.
// Optional occupancy counter output enabled by defining FIFO_W2N_OCCUPANCY_EN.
module fifo_w2n_flush #(
  parameter int DEPTH    = 4,
  parameter int WR_WIDTH = 32,
  parameter int RD_WIDTH = 4,
  parameter int CNT_W    = $clog2(WR_WIDTH / RD_WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [WR_WIDTH-1:0] wr_data,
  input  logic [CNT_W-1:0]    wr_nibs,
  input  logic                rd,
  output logic [RD_WIDTH-1:0] rd_data,
  output logic                rd_last,
  output logic                data_avail,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                empty,
  output logic                full
`ifdef FIFO_W2N_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH*(WR_WIDTH/RD_WIDTH)+1)-1:0] occ
`endif
);

  localparam int NIBS = WR_WIDTH / RD_WIDTH;
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int NW   = $clog2(NIBS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [WR_WIDTH-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0]    cnt_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [PW-1:0]       tgt_r;
  logic [NW-1:0]       nib_ptr_r;
  logic [1:0]          state_r;

  logic [WR_WIDTH-1:0] head_word_s;
  logic [CNT_W-1:0]    head_cnt_s;
  logic                empty_s;
  logic                full_s;
  logic                wr_en_s;
  logic                avail_s;
  logic                rd_en_s;
  logic                last_s;
  logic                discard_s;
  logic [RD_WIDTH-1:0] rd_data_s;

  // Status decode and head-nibble selection
  always_comb begin
    head_word_s = mem_r[rd_ptr_r[AW-1:0]];
    head_cnt_s  = cnt_r[rd_ptr_r[AW-1:0]];
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    wr_en_s     = wr && !full_s;
    avail_s     = !empty_s && (state_r == IDLE);
    rd_en_s     = rd && avail_s;
    last_s      = avail_s && (CNT_W'(nib_ptr_r) == head_cnt_s - CNT_W'(1));
    discard_s   = (state_r == FLUSH) && (rd_ptr_r != tgt_r);
    if (avail_s) begin
      rd_data_s = head_word_s[nib_ptr_r*RD_WIDTH +: RD_WIDTH];
    end else begin
      rd_data_s = '0;
    end
  end

  assign rd_data    = rd_data_s;
  assign rd_last    = last_s;
  assign data_avail = avail_s;
  assign empty      = empty_s;
  assign full       = full_s;
  assign flush_done = (state_r == DONE);

  // Entry storage; writes are accepted in every FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
      cnt_r[wr_ptr_r[AW-1:0]] <= wr_nibs;
    end
  end

  // Write pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
    end else if (wr_en_s) begin
      wr_ptr_r <= wr_ptr_r + PW'(1);
    end
  end

  // Read side and flush FSM; tgt snapshots wr_ptr including a same-cycle write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      rd_ptr_r  <= '0;
      nib_ptr_r <= '0;
      tgt_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_en_s) begin
            if (last_s) begin
              nib_ptr_r <= '0;
              rd_ptr_r  <= rd_ptr_r + PW'(1);
            end else begin
              nib_ptr_r <= nib_ptr_r + NW'(1);
            end
          end
          if (flush_req) begin
            state_r <= FLUSH;
            tgt_r   <= wr_ptr_r + PW'(wr_en_s);
          end
        end
        FLUSH: begin
          nib_ptr_r <= '0;
          if (discard_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
            if (rd_ptr_r + PW'(1) == tgt_r) begin
              state_r <= DONE;
            end
          end else begin
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_W2N_OCCUPANCY_EN
  localparam int OW = $clog2(DEPTH * NIBS + 1);

  logic [OW-1:0] occ_r;
  logic [OW-1:0] occ_add_s;
  logic [OW-1:0] occ_sub_s;

  // Occupancy deltas: a discarded head only removes its unread remainder
  always_comb begin
    if (wr_en_s) begin
      occ_add_s = OW'(wr_nibs);
    end else begin
      occ_add_s = '0;
    end
    if (discard_s) begin
      occ_sub_s = OW'(head_cnt_s - CNT_W'(nib_ptr_r));
    end else if (rd_en_s) begin
      occ_sub_s = OW'(1);
    end else begin
      occ_sub_s = '0;
    end
  end

  // Occupancy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= '0;
    end else begin
      occ_r <= occ_r + occ_add_s - occ_sub_s;
    end
  end

  assign occ = occ_r;
`endif

endmodule

// File: tb/tb_fifo_w2n_flush.sv
// Scoreboard bench for fifo_w2n_flush: expected nibbles are queued on write and checked on pop.
module tb_fifo_w2n_flush;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  wr_nibs = 4'h0;
  logic        rd = 1'b0;
  logic [3:0]  rd_data;
  logic        rd_last;
  logic        data_avail;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic        empty;
  logic        full;
`ifdef FIFO_W2N_OCCUPANCY_EN
  logic [5:0]  occ;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];
  int         ent_q[$];

  fifo_w2n_flush dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_data(wr_data), .wr_nibs(wr_nibs),
    .rd(rd), .rd_data(rd_data), .rd_last(rd_last), .data_avail(data_avail),
    .flush_req(flush_req), .flush_done(flush_done), .empty(empty), .full(full)
`ifdef FIFO_W2N_OCCUPANCY_EN
    , .occ(occ)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_occ(input string tag);
`ifdef FIFO_W2N_OCCUPANCY_EN
    check_val(tag, 32'(occ), 32'(exp_q.size()));
`endif
  endtask

  task automatic model_write(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), d[i*4 +: 4]});
    end
    ent_q.push_back(n);
  endtask

  task automatic write_word(input logic [31:0] d, input int n);
    wr = 1'b1; wr_data = d; wr_nibs = 4'(n);
    model_write(d, n);
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic pop_nib(input string tag);
    logic [4:0] e;
    rd = 1'b1;
    #1;
    check_val({tag, "_avail"}, 32'(data_avail), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 5'h1f;
    check_val({tag, "_data"}, 32'(rd_data), 32'(e[3:0]));
    check_val({tag, "_last"}, 32'(rd_last), 32'(e[4]));
    if (ent_q.size() > 0) begin
      ent_q[0] = ent_q[0] - 1;
      if (ent_q[0] == 0) void'(ent_q.pop_front());
    end
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      pop_nib(tag);
      guard++;
    end
    check_val({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  // Flush at cycle N (optional same-cycle write), optional write at N+1; checks latency and one-cycle pulse
  task automatic do_flush(input string tag, input bit w1, input logic [31:0] d1,
                          input bit w2, input logic [31:0] d2, input int exp_lat);
    int seen = 0;
    int k;
    int n;
    flush_req = 1'b1;
    if (w1) begin
      wr = 1'b1; wr_data = d1; wr_nibs = 4'd8;
      model_write(d1, 8);
    end
    k = ent_q.size();
    for (int j = 0; j < k; j++) begin
      n = ent_q.pop_front();
      for (int m = 0; m < n; m++) void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    wr = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      if (t == 1 && w2) begin
        wr = 1'b1; wr_data = d2; wr_nibs = 4'd8;
        model_write(d2, 8);
      end
      #1;
      check_val({tag, "_noavail"}, 32'(data_avail), 32'd0);
      if (flush_done) begin
        seen = t;
        flush_req = 1'b0;
        break;
      end
      @(posedge clk); #1;
      wr = 1'b0;
    end
    wr = 1'b0;
    flush_req = 1'b0;
    check_val({tag, "_lat"}, 32'(seen), 32'(exp_lat));
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, 32'(flush_done), 32'd0);
  endtask

  initial begin
    // Power-on reset
    #12;
    check_val("por_empty", 32'(empty), 32'd1);
    check_val("por_full", 32'(full), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 1: reset asserted mid-traffic
    write_word(32'h55555555, 8);
    write_word(32'h66666666, 8);
    pop_nib("pre_rst");
    rd = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_avail", 32'(data_avail), 32'd0);
    check_val("rst_data", 32'(rd_data), 32'd0);
    check_val("rst_last", 32'(rd_last), 32'd0);
    check_val("rst_done", 32'(flush_done), 32'd0);
    rd = 1'b0;
    exp_q.delete();
    ent_q.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_occ("rst_occ");
    write_word(32'h76543210, 8);
    drain("t1");

    // 2: full-word read order and last flag
    write_word(32'h76543210, 8);
    drain("t2");

    // 3: partial entries
    write_word(32'hDEADBEEF, 3);
    write_word(32'h0000000A, 1);
    drain("t3");

    // 4: fill, free one entry, wrap
    for (int i = 0; i < 4; i++) write_word(32'h10325476 + 32'(i) * 32'h11111111, 8);
    check_val("t4_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_val("t4_still_full", 32'(full), 32'd1);
      pop_nib("t4_head");
    end
    check_val("t4_full_clr", 32'(full), 32'd0);
    write_word(32'h13572468, 8);
    chk_occ("t4_occ");
    drain("t4");

    // 5: flush with partially read head, same-cycle write and a write right after
    write_word(32'h89ABCDEF, 8);
    write_word(32'h01234567, 8);
    pop_nib("t5_pre");
    pop_nib("t5_pre");
    do_flush("t5", 1'b1, 32'h11111111, 1'b1, 32'hCAFEF00D, 4);
    chk_occ("t5_occ");
    check_val("t5_left", 32'(exp_q.size()), 32'd8);
    drain("t5");

    // 6: occupancy across write/read/flush, then flush on empty FIFO
    chk_occ("t6_occ0");
    write_word(32'h76543210, 8);
    chk_occ("t6_occ8");
    for (int i = 0; i < 5; i++) pop_nib("t6_rd");
    chk_occ("t6_occ3");
    do_flush("t6a", 1'b0, 32'h0, 1'b0, 32'h0, 2);
    chk_occ("t6_occ_flushed");
    check_val("t6_empty", 32'(empty), 32'd1);
    do_flush("t6b", 1'b0, 32'h0, 1'b0, 32'h0, 2);
    check_val("t6b_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_w2n_flush.md
Name: fifo_w2n_flush

Overview:
Asymmetric down-converting FIFO. A 32-bit producer writes words, each with a valid-nibble count. A 4-bit consumer pops one nibble per cycle. Storage is exactly 128 bits of payload (4 words) plus per-entry nibble counts. A flush request discards all data written before and on the flush cycle, while writes continue to be accepted during the flush.

Parameters:
DEPTH, 4, number of 32-bit entries (power of 2).
WR_WIDTH, 32, write word width.
RD_WIDTH, 4, read width; NIBS = WR_WIDTH/RD_WIDTH = 8.
CNT_W, $clog2(NIBS+1) = 4, width of the nibble-count field.

Ports:
clk  in  1  clock, all flops posedge.
rst  in  1  reset, asynchronous, active-low.
wr  in  1  write strobe; never asserted while full=1.
wr_data  in  WR_WIDTH  write word; nibble 0 = bits [3:0] is read first.
wr_nibs  in  CNT_W  valid nibbles in wr_data, legal 1..NIBS.
rd  in  1  pop one nibble; only asserted while data_avail=1.
rd_data  out  RD_WIDTH  head nibble, combinational, valid in the same cycle as rd.
rd_last  out  1  head nibble is the last valid nibble of its entry.
data_avail  out  1  at least one nibble is readable.
flush_req  in  1  level; held until flush_done is seen, then dropped.
flush_done  out  1  one-cycle pulse, flush complete.
empty  out  1  no stored entries.
full  out  1  DEPTH entries stored.

Behaviour:
- Storage: mem[DEPTH] of WR_WIDTH bits and cnt[DEPTH] of CNT_W bits.
- wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, with an MSB wrap bit.
- nib_ptr is $clog2(NIBS) bits and indexes the head entry.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) && (lower bits equal).
- Write: wr && !full stores wr_data/wr_nibs at mem[wr_ptr] and increments wr_ptr. The write is accepted in every FSM state.
- data_avail = !empty && state==IDLE.
- rd_data = mem[rd_ptr][nib_ptr*4 +: 4] when data_avail, else 0.
- rd_last = data_avail && (nib_ptr == cnt[rd_ptr]-1).
- Read: rd && data_avail increments nib_ptr. If rd_last is also high, nib_ptr clears to 0 and rd_ptr increments, freeing the entry at the next edge.
- full deasserts the cycle after the last nibble of a full FIFO's head entry is read.
- FSM states IDLE, FLUSH, DONE; reset state IDLE.
- IDLE → FLUSH when flush_req is high. On that cycle, tgt <= wr_ptr + (wr && !full), so a same-cycle write is included in the flush.
- FLUSH:
  - rd is ignored and nib_ptr is held at 0.
  - If rd_ptr != tgt, one entry is discarded per cycle (rd_ptr++).
  - Go to DONE when rd_ptr == tgt, or when rd_ptr+1 == tgt while discarding.
  - A partially read head entry is discarded whole.
- DONE: flush_done=1 for exactly this cycle, then return to IDLE.
- Flush latency: with flush_req first high at cycle N and k entries captured, flush_done is high at cycle N+max(k,1)+1.
- Writes at cycles ≥ N+1 are never discarded.
- A flush on an empty FIFO is legal and completes at N+2.
- flush_req is ignored in FLUSH and DONE. In IDLE it starts a new flush only after it has dropped, because the requester releases it on seeing flush_done.
- Pointer wrap: natural modulo 2*DEPTH; tgt uses the same width.
- Reset, including mid-flush or mid-word, values:
  - Pointers, nib_ptr, tgt = 0; state = IDLE.
  - mem and cnt cleared.
  - empty=1, full=0, data_avail=0, rd_last=0, rd_data=0, flush_done=0.

Optional Feature:
FIFO_W2N_OCCUPANCY_EN:
- Defined: adds output occ [$clog2(DEPTH*NIBS+1)-1:0], the count of unread valid nibbles.
  - occ = sum of cnt[] over stored entries, minus nib_ptr.
  - It is a registered counter: +wr_nibs on a write, -1 on a read, and -(cnt[rd_ptr]-nib_ptr) on a flush discard.
  - Reset value is 0.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
1. Reset asserted mid-traffic → empty=1, full=0, data_avail=0, rd_data=0x0, flush_done=0. A post-reset read of 0x76543210/8 returns nibbles 0..7.
2. Write 0x76543210, wr_nibs=8; rd for 8 cycles → rd_data 0,1,2,…,7, rd_last only on nibble 7. empty=1 on the next cycle.
3. Write 0xDEADBEEF, wr_nibs=3; read → F, E, E with rd_last on the 3rd. Next entry 0x0000000A/1 → A with rd_last=1.
4. Write 4 words → full=1. Read 8 nibbles of the head → full=0 the cycle after the 8th. Write a 5th word 0x13572468 and drain → ordering preserved across the pointer wrap.
5. Two entries stored with 2 nibbles of the head read. At cycle N assert flush_req with a same-cycle write of 0x11111111/8, and write 0xCAFEF00D/8 at N+1 → data_avail=0 during the flush, flush_done at N+4. Then the reads return D,0,0,F,E,F,A,C only, and empty=1.
6. flush_req on an empty FIFO → flush_done pulses at N+2 for one cycle. With the occupancy feature enabled, occ tracks 0→8→3 across write/read/flush.
